// File: rtl/usr_seq_ctrl.sv
// Command sequencer for a universal shift register: LOAD / SHR / SHL / LOAD_SHL with a done pulse.
// Optional rotate fill is enabled by defining USR_SEQ_ROTATE_EN (adds the cmd_rot input).
module usr_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [WIDTH-1:0] cmd_data,
`ifdef USR_SEQ_ROTATE_EN
    input  logic             cmd_rot,
`endif
    input  logic             ser_in,
    output logic             ser_out,
    output logic             ser_out_valid,
    output logic             usr_s1,
    output logic             usr_s0,
    output logic [WIDTH-1:0] usr_i_par,
    output logic             usr_msb_in,
    output logic             usr_lsb_in,
    input  logic [WIDTH-1:0] usr_a_par,
    output logic             done,
    output logic [WIDTH-1:0] rsp_data
);

    localparam logic [1:0] OP_LOAD     = 2'b00;
    localparam logic [1:0] OP_SHR      = 2'b01;
    localparam logic [1:0] OP_SHL      = 2'b10;
    localparam logic [1:0] OP_LOAD_SHL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_LOAD  = 2'b01,
        S_SHIFT = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t           state;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rot_q;
    logic [CNT_W-1:0] cnt_clamped;
    logic             rot_in;

`ifdef USR_SEQ_ROTATE_EN
    assign rot_in = cmd_rot;
`else
    assign rot_in = 1'b0;
`endif

    assign cnt_clamped = (cmd_cnt > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : cmd_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            op_q   <= '0;
            data_q <= '0;
            cnt_q  <= '0;
            rot_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q   <= cmd_op;
                        data_q <= cmd_data;
                        cnt_q  <= cnt_clamped;
                        rot_q  <= rot_in;
                        if (cmd_op == OP_LOAD || cmd_op == OP_LOAD_SHL)
                            state <= S_LOAD;
                        else if (cnt_clamped != '0)
                            state <= S_SHIFT;
                        else
                            state <= S_DONE;
                    end
                end
                S_LOAD: begin
                    if (op_q == OP_LOAD_SHL && cnt_q != '0)
                        state <= S_SHIFT;
                    else
                        state <= S_DONE;
                end
                S_SHIFT: begin
                    cnt_q <= cnt_q - 1'b1;
                    // <= 1 rather than == 1 so a zero count can never wrap into a long shift
                    if (cnt_q <= CNT_W'(1))
                        state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        cmd_ready     = 1'b0;
        usr_s1        = 1'b0;
        usr_s0        = 1'b0;
        usr_i_par     = '0;
        usr_msb_in    = 1'b0;
        usr_lsb_in    = 1'b0;
        ser_out       = 1'b0;
        ser_out_valid = 1'b0;
        done          = 1'b0;
        rsp_data      = '0;
        case (state)
            S_IDLE: cmd_ready = 1'b1;
            S_LOAD: begin
                usr_s1    = 1'b1;
                usr_s0    = 1'b1;
                usr_i_par = data_q;
            end
            S_SHIFT: begin
                ser_out_valid = 1'b1;
                if (op_q == OP_SHR) begin
                    usr_s0     = 1'b1;
                    ser_out    = usr_a_par[0];
                    usr_msb_in = rot_q ? usr_a_par[0] : ser_in;
                end else begin
                    usr_s1     = 1'b1;
                    ser_out    = usr_a_par[WIDTH-1];
                    usr_lsb_in = rot_q ? usr_a_par[WIDTH-1] : ser_in;
                end
            end
            S_DONE: begin
                done     = 1'b1;
                rsp_data = usr_a_par;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/usr_seq_ctrl.md
Name: usr_seq_ctrl

Overview:
Command-driven sequencer for the team's 4-bit universal shift register (parallel load, shift-left, shift-right, hold). It accepts one command at a time over a valid/ready handshake and drives the register's select lines, parallel data and serial-fill inputs for the required number of cycles. It then returns the register contents with a one-cycle done pulse. It sits between a host/serial-link FSM and the shift register, and turns it into a word serializer/deserializer.

Parameters:
WIDTH, 4, width of the controlled register and of cmd_data/rsp_data
CNT_W, 3, width of cmd_cnt; must hold the value WIDTH

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command (high only in IDLE)
cmd_op  input  2  00 LOAD, 01 SHR, 10 SHL, 11 LOAD_SHL
cmd_cnt  input  CNT_W  shift count; 0 = no shift; values >WIDTH clamp to WIDTH
cmd_data  input  WIDTH  parallel word for LOAD / LOAD_SHL
ser_in  input  1  serial fill bit shifted into the register
ser_out  output  1  bit leaving the register this cycle
ser_out_valid  output  1  high on every SHIFT-state cycle
usr_s1, usr_s0  output  1 each  register mode select: 00 hold, 01 right, 10 left, 11 load
usr_i_par  output  WIDTH  parallel load data to the register
usr_msb_in  output  1  right-shift fill bit
usr_lsb_in  output  1  left-shift fill bit
usr_a_par  input  WIDTH  current register contents
done  output  1  one-cycle pulse at end of command
rsp_data  output  WIDTH  register contents, valid while done=1

Behaviour:
- States: IDLE, LOAD, SHIFT, DONE. State, latched op, data and remaining count are registered.
- All usr_* and ser_* outputs decode combinationally from the registered state and latched command, so the register acts on the clock edge that ends each state cycle.
- Reset (asynchronous, any state): state=IDLE, count=0, latched op/data=0.
  - Outputs after reset: usr_s1/s0=00, usr_i_par=0, done=0, ser_out_valid=0, cmd_ready=1.
  - Reset mid-command abandons the command with no done pulse.
- IDLE:
  - cmd_ready=1, selects=00.
  - On cmd_valid&&cmd_ready, latch op, data and clamp(cmd_cnt).
  - Next state: LOAD for LOAD or LOAD_SHL. SHIFT for SHR/SHL with cnt>0. DONE for SHR/SHL with cnt=0.
- LOAD: one cycle.
  - Selects=11, usr_i_par=latched data.
  - Next state: DONE for LOAD. SHIFT for LOAD_SHL if cnt>0, otherwise DONE.
- SHIFT: exactly cnt cycles, count decrements each cycle.
  - SHR: selects=01, usr_msb_in=ser_in, ser_out=usr_a_par[0].
  - SHL and LOAD_SHL: selects=10, usr_lsb_in=ser_in, ser_out=usr_a_par[WIDTH-1].
  - Unused fill input is driven 0.
  - Leave to DONE when count reaches 1.
- DONE: one cycle.
  - Selects=00, done=1, rsp_data=usr_a_par (post-operation value).
  - Next state: IDLE.
- cmd_ready=0 outside IDLE. Commands are not queued, so back-to-back throughput is one command per (latency+1) cycles.
- Latency from the accept edge at cycle T:
  - LOAD: done at T+2.
  - SHR/SHL n: done at T+n+1.
  - LOAD_SHL n: done at T+n+2.
  - cnt=0 shift: done at T+1.
- Illegal state encodings recover to IDLE.

Optional Feature:
USR_SEQ_ROTATE_EN
- Defined: adds input cmd_rot (1 bit), latched at accept. When the latched value is 1, SHIFT fills from the outgoing bit instead of ser_in, giving a rotate:
  - SHL: usr_lsb_in=usr_a_par[WIDTH-1].
  - SHR: usr_msb_in=usr_a_par[0].
  - ser_out and ser_out_valid behave unchanged.
- Undefined: cmd_rot port is absent and fill is always ser_in.

Test Plan:
1. Reset low mid-SHIFT -> next cycle state IDLE, selects=00, cmd_ready=1, no done; release reset -> idle selects stay 00.
2. LOAD data=1011 accepted at T -> selects=11 at T+1; done=1 with rsp_data=1011 at T+2.
3. After (2), SHR cnt=2, ser_in=1 -> ser_out 1,1 on T+1..T+2; rsp_data=1110 at T+3.
4. LOAD_SHL data=1011 cnt=4 ser_in=0 -> ser_out 1,0,1,1 on T+2..T+5; done at T+6 with rsp_data=0000.
5. SHL cnt=7 (clamped to 4) on 0110, ser_in=1 -> 4 shift cycles; rsp_data=1111. Then SHL cnt=0 -> no shift, done at T+1, rsp_data unchanged. cmd_valid held during a busy command is not accepted until cmd_ready=1.
6. (USR_SEQ_ROTATE_EN) LOAD 1001, then SHL cnt=1 cmd_rot=1 -> rsp_data=0011; SHR cnt=1 cmd_rot=1 on 0011 -> rsp_data=1001.
